// File: rtl/hazard_sched.sv
// Decode-stage hazard controller: forward selects, load/branch stalls, taken-branch
// flush, dmem freeze sequencing with watchdog, halt drain and a stall-cycle counter.
module hazard_sched #(
  parameter int MAX_FREEZE = 64,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [2:0]       id_rs,
  input  logic [2:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_early,
  input  logic             id_taken,
  input  logic             id_halt,
  input  logic             ex_valid,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic [2:0]       ex_rd,
  input  logic             mem_valid,
  input  logic             mem_regwrite,
  input  logic             mem_memread,
  input  logic [2:0]       mem_rd,
  input  logic             wb_valid,
  input  logic             wb_regwrite,
  input  logic [2:0]       wb_rd,
  input  logic             dmem_stall,
  output logic [1:0]       fwd_A,
  output logic [1:0]       fwd_B,
  output logic             stall_fe,
  output logic             bubble_idex,
  output logic             flush_ifid,
  output logic             freeze,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [1:0]       state_dbg
);

  // Control handshake: there is no valid/ready pair here; every output is a
  // per-cycle level that the pipeline samples at the next clk edge.

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FREEZE = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t           state_q, state_d;
  state_t           ret_q, ret_d;
  state_t           eff;
  logic [7:0]       freeze_cnt_q, freeze_cnt_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_q;

  logic ex_w, mem_alu, mem_ld, wb_w;
  logic a_mem, a_wb, b_mem, b_wb;
  logic haz_a, haz_b, haz;

  assign ex_w    = ex_valid & ex_regwrite;
  assign mem_alu = mem_valid & mem_regwrite & ~mem_memread;
  assign mem_ld  = mem_valid & mem_regwrite & mem_memread;
  assign wb_w    = wb_valid & wb_regwrite;

  assign a_mem = id_uses_rs & mem_alu & (mem_rd == id_rs);
  assign a_wb  = id_uses_rs & ~a_mem & wb_w & (wb_rd == id_rs);
  assign b_mem = id_uses_rt & mem_alu & (mem_rd == id_rt);
  assign b_wb  = id_uses_rt & ~b_mem & wb_w & (wb_rd == id_rt);

  assign fwd_A = {a_mem, a_wb};
  assign fwd_B = {b_mem, b_wb};

  // A load still in MEM can only be forwarded from WB, so early consumers wait on it too.
  assign haz_a = id_uses_rs & ((ex_w & (ex_rd == id_rs) & (ex_memread | id_early)) |
                               (mem_ld & (mem_rd == id_rs) & id_early));
  assign haz_b = id_uses_rt & ((ex_w & (ex_rd == id_rt) & (ex_memread | id_early)) |
                               (mem_ld & (mem_rd == id_rt) & id_early));
  assign haz   = id_valid & (haz_a | haz_b);

  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    stall_fe    = 1'b0;
    bubble_idex = 1'b0;
    flush_ifid  = 1'b0;
    freeze      = 1'b0;
    halted      = 1'b0;
    // A freeze cycle that ends behaves exactly like the state it interrupted.
    eff = (state_q == FREEZE) ? ret_q : state_q;
    if (eff != HALTED && dmem_stall) begin
      freeze  = 1'b1;
      state_d = FREEZE;
      ret_d   = eff;
    end else begin
      case (eff)
        RUN: begin
          stall_fe    = haz;
          bubble_idex = haz;
          flush_ifid  = id_valid & id_taken & ~haz;
          state_d     = (id_valid & id_halt & ~haz) ? DRAIN : RUN;
        end
        DRAIN: begin
          stall_fe    = 1'b1;
          bubble_idex = 1'b1;
          state_d     = (~ex_valid & ~mem_valid & ~wb_valid) ? HALTED : DRAIN;
        end
        HALTED: begin
          halted   = 1'b1;
          stall_fe = 1'b1;
          state_d  = HALTED;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    freeze_cnt_d = 8'd0;
    err_d        = err_q;
    if (freeze) begin
      freeze_cnt_d = (freeze_cnt_q == 8'hff) ? freeze_cnt_q : freeze_cnt_q + 8'd1;
      if (int'(freeze_cnt_q) + 1 >= MAX_FREEZE) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= RUN;
      ret_q        <= RUN;
      freeze_cnt_q <= 8'd0;
      err_q        <= 1'b0;
      stall_q      <= '0;
    end else begin
      state_q      <= state_d;
      ret_q        <= ret_d;
      freeze_cnt_q <= freeze_cnt_d;
      err_q        <= err_d;
      if (stall_fe && stall_q != {CNT_W{1'b1}}) stall_q <= stall_q + 1'b1;
    end
  end

  assign err          = err_q;
  assign stall_cycles = stall_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_hazard_sched.sv
// Bench for hazard_sched: directed scenarios plus random traffic, all outputs
// compared every cycle against a behavioural model of the hazard rules.
module tb_hazard_sched;
  localparam int MAX_FREEZE = 64;
  localparam int CNT_W      = 6;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  logic id_valid, id_uses_rs, id_uses_rt, id_early, id_taken, id_halt;
  logic [2:0] id_rs, id_rt, ex_rd, mem_rd, wb_rd;
  logic ex_valid, ex_regwrite, ex_memread;
  logic mem_valid, mem_regwrite, mem_memread;
  logic wb_valid, wb_regwrite, dmem_stall;
  logic [1:0] fwd_A, fwd_B, state_dbg;
  logic stall_fe, bubble_idex, flush_ifid, freeze, halted, err;
  logic [CNT_W-1:0] stall_cycles;

  int checks = 0;
  int failures = 0;

  // model state: phase 0=running 1=draining 2=halted
  int ph, run_len, stall_m;
  bit err_m;

  always #5 clk = ~clk;

  hazard_sched #(.MAX_FREEZE(MAX_FREEZE), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_early(id_early), .id_taken(id_taken), .id_halt(id_halt),
    .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .mem_valid(mem_valid), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_rd(mem_rd),
    .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
    .dmem_stall(dmem_stall),
    .fwd_A(fwd_A), .fwd_B(fwd_B), .stall_fe(stall_fe), .bubble_idex(bubble_idex),
    .flush_ifid(flush_ifid), .freeze(freeze), .halted(halted), .err(err),
    .stall_cycles(stall_cycles), .state_dbg(state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Which stage supplies source s: the youngest non-load writer that already has its value.
  function automatic logic [1:0] fwd_m(input logic [2:0] s, input logic used);
    if (!used) return 2'b00;
    if (mem_valid && mem_regwrite && !mem_memread && mem_rd == s) return 2'b10;
    if (wb_valid && wb_regwrite && wb_rd == s) return 2'b01;
    return 2'b00;
  endfunction

  // Source s is not yet obtainable this cycle.
  function automatic bit blocked_m(input logic [2:0] s, input logic used);
    bit ex_hit, mem_ld_hit;
    if (!used) return 0;
    ex_hit     = ex_valid && ex_regwrite && ex_rd == s;
    mem_ld_hit = mem_valid && mem_regwrite && mem_memread && mem_rd == s;
    if (ex_hit && (ex_memread || id_early)) return 1;
    if (mem_ld_hit && id_early) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    ph = 0; run_len = 0; stall_m = 0; err_m = 0;
  endtask

  task automatic idle();
    id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
    id_early = 0; id_taken = 0; id_halt = 0;
    ex_valid = 0; ex_regwrite = 0; ex_memread = 0; ex_rd = 0;
    mem_valid = 0; mem_regwrite = 0; mem_memread = 0; mem_rd = 0;
    wb_valid = 0; wb_regwrite = 0; wb_rd = 0; dmem_stall = 0;
  endtask

  // Called just after a negedge with inputs already driven; checks, then advances the model.
  task automatic cycle();
    bit frz, hz;
    bit e_stall, e_bubble, e_flush;
    #1;
    frz = dmem_stall && ph != 2;
    hz  = id_valid && (blocked_m(id_rs, id_uses_rs) || blocked_m(id_rt, id_uses_rt));
    e_stall  = !frz && (ph == 0 ? hz : 1'b1);
    e_bubble = !frz && (ph == 0 ? hz : ph == 1);
    e_flush  = !frz && ph == 0 && id_valid && id_taken && !hz;
    check("fwd_A", 32'(fwd_A), 32'(fwd_m(id_rs, id_uses_rs)));
    check("fwd_B", 32'(fwd_B), 32'(fwd_m(id_rt, id_uses_rt)));
    check("stall_fe", 32'(stall_fe), 32'(e_stall));
    check("bubble_idex", 32'(bubble_idex), 32'(e_bubble));
    check("flush_ifid", 32'(flush_ifid), 32'(e_flush));
    check("freeze", 32'(freeze), 32'(frz));
    check("halted", 32'(halted), 32'(ph == 2));
    check("err", 32'(err), 32'(err_m));
    check("stall_cycles", 32'(stall_cycles), 32'(stall_m));
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else begin
      if (e_stall && stall_m < CNT_MAX) stall_m++;
      if (frz) begin
        run_len++;
        if (run_len >= MAX_FREEZE) err_m = 1;
      end else begin
        run_len = 0;
        if (ph == 0 && id_valid && id_halt && !hz) ph = 1;
        else if (ph == 1 && !ex_valid && !mem_valid && !wb_valid) ph = 2;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    idle();
    model_reset();
    rst = 0;
    @(negedge clk);
    cycle();
    rst = 1;
    cycle();

    // load r1 in EX feeding BEQZ r1 in decode
    idle(); id_valid = 1; id_rs = 3'd1; id_uses_rs = 1; id_early = 1;
    ex_valid = 1; ex_regwrite = 1; ex_memread = 1; ex_rd = 3'd1;
    cycle();
    ex_valid = 0; ex_regwrite = 0; ex_memread = 0;
    mem_valid = 1; mem_regwrite = 1; mem_memread = 1; mem_rd = 3'd1;
    cycle();
    mem_valid = 0; mem_regwrite = 0; mem_memread = 0;
    wb_valid = 1; wb_regwrite = 1; wb_rd = 3'd1;
    cycle();
    check("load_branch_stalls", 32'(stall_cycles), 32'd2);

    // ALU writers of r2 in both MEM and WB
    idle(); id_valid = 1; id_rs = 3'd2; id_uses_rs = 1; id_rt = 3'd2; id_uses_rt = 1;
    mem_valid = 1; mem_regwrite = 1; mem_rd = 3'd2;
    wb_valid = 1; wb_regwrite = 1; wb_rd = 3'd2;
    cycle();
    check("mem_priority", 32'(fwd_A), 32'd2);

    // taken branch during dmem stall, then released
    idle(); id_valid = 1; id_taken = 1; dmem_stall = 1;
    cycle();
    dmem_stall = 0;
    cycle();

    // watchdog
    idle(); dmem_stall = 1;
    for (int i = 0; i < MAX_FREEZE; i++) cycle();
    dmem_stall = 0;
    cycle();
    check("err_sticky", 32'(err), 32'd1);
    cycle();

    // halt drain with EX, MEM, WB occupied
    idle(); id_valid = 1; id_halt = 1; ex_valid = 1; mem_valid = 1; wb_valid = 1;
    cycle();
    idle(); mem_valid = 1; wb_valid = 1;
    cycle();
    idle(); wb_valid = 1;
    cycle();
    idle();
    cycle();
    for (int i = 0; i < 70; i++) cycle();
    check("halted_after_drain", 32'(halted), 32'd1);
    rst = 0;
    cycle();
    rst = 1;
    cycle();

    // random traffic
    for (int n = 0; n < 4000; n++) begin
      idle();
      rst        = ($urandom_range(0, 79) != 0);
      id_valid   = ($urandom_range(0, 3) != 0);
      id_rs      = 3'($urandom_range(0, 3));
      id_rt      = 3'($urandom_range(0, 3));
      id_uses_rs = 1'($urandom);
      id_uses_rt = 1'($urandom);
      id_early   = 1'($urandom);
      id_taken   = 1'($urandom);
      id_halt    = ($urandom_range(0, 39) == 0);
      ex_valid   = 1'($urandom); ex_regwrite  = 1'($urandom); ex_memread  = 1'($urandom);
      ex_rd      = 3'($urandom_range(0, 3));
      mem_valid  = 1'($urandom); mem_regwrite = 1'($urandom); mem_memread = 1'($urandom);
      mem_rd     = 3'($urandom_range(0, 3));
      wb_valid   = 1'($urandom); wb_regwrite  = 1'($urandom);
      wb_rd      = 3'($urandom_range(0, 3));
      dmem_stall = ($urandom_range(0, 7) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hazard_sched.md
Name: hazard_sched

Overview:
- Pipeline hazard controller for the 5-stage core whose decode stage resolves branches and JR targets with forwarded operands.
- Each cycle it produces the decode-stage forward selects (fwd_A/fwd_B), and the stall, bubble, flush and freeze controls for fetch, IF/ID and ID/EX.
- It sequences data-memory-stall freezes (with a watchdog) and the halt drain.
- It keeps a saturating stall-cycle performance counter.

Parameters:
- MAX_FREEZE, 64, maximum consecutive dmem_stall cycles before err asserts (range 1..255).
- CNT_W, 16, width of stall_cycles.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-low reset.
- id_valid  in  1  decode holds a real instruction.
- id_rs  in  3  decode source register A (instruct[10:8]).
- id_rt  in  3  decode source register B (instruct[7:5]).
- id_uses_rs  in  1  decode reads rs.
- id_uses_rt  in  1  decode reads rt.
- id_early  in  1  decode consumes operands in decode (conditional branch or JR/JALR).
- id_taken  in  1  decode redirects PC this cycle.
- id_halt  in  1  decode holds HALT.
- ex_valid, ex_regwrite, ex_memread  in  1 each  EX-stage instruction status.
- ex_rd  in  3  EX-stage resolved destination register.
- mem_valid, mem_regwrite, mem_memread  in  1 each  MEM-stage instruction status (its ALU result is data_exmem).
- mem_rd  in  3  MEM-stage resolved destination register.
- wb_valid, wb_regwrite  in  1 each  WB-stage instruction status (its result is data_memwb).
- wb_rd  in  3  WB-stage resolved destination register.
- dmem_stall  in  1  data memory busy.
- fwd_A  out  2  decode operand A source: 2'b10 data_exmem, 2'b01 data_memwb, 2'b00 register file.
- fwd_B  out  2  decode operand B source, same encoding as fwd_A.
- stall_fe  out  1  hold PC and IF/ID.
- bubble_idex  out  1  load NOP into ID/EX.
- flush_ifid  out  1  squash IF/ID.
- freeze  out  1  hold every pipeline register.
- halted  out  1  core halted.
- err  out  1  freeze watchdog expired (sticky).
- stall_cycles  out  CNT_W  saturating count of stall_fe cycles.

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=RUN, freeze_cnt=0, err=0, stall_cycles=0.
  - All combinational outputs are 0 while state is RUN and inputs are idle.
- Forwarding is combinational and evaluated per source s (rs with id_uses_rs; rt with id_uses_rt). It is 00 when the source is unused.
  - bit1 = mem_valid & mem_regwrite & ~mem_memread & mem_rd==s.
  - bit0 = ~bit1 & wb_valid & wb_regwrite & wb_rd==s.
  - MEM has priority over WB.
- Data-hazard stall (haz) is asserted when id_valid, a used source s, and either of:
  - ex_valid & ex_regwrite & ex_rd==s & (ex_memread | id_early);
  - mem_valid & mem_regwrite & mem_memread & mem_rd==s & id_early.
- A load feeding a branch therefore costs exactly 2 stall cycles; an ALU op feeding a branch costs 1; a load feeding an ALU op costs 1.
- haz outputs: stall_fe=1, bubble_idex=1, flush_ifid=0.
- flush_ifid = id_valid & id_taken & ~haz & ~freeze.
- States:
  - RUN:
    - dmem_stall → FREEZE; the same cycle freeze=1 and all other controls are forced to 0.
    - else id_valid & id_halt & ~haz → DRAIN.
  - FREEZE:
    - freeze = dmem_stall; freeze_cnt increments each cycle dmem_stall is high.
    - When freeze_cnt reaches MAX_FREEZE, err←1 (sticky until reset).
    - On dmem_stall==0: freeze_cnt←0 and return to the prior state (RUN or DRAIN); normal evaluation resumes that cycle.
  - DRAIN:
    - stall_fe=1 every cycle; bubble_idex=1.
    - dmem_stall → FREEZE (return to DRAIN afterwards).
    - When ex_valid, mem_valid and wb_valid are all 0 → HALTED.
  - HALTED:
    - halted=1, stall_fe=1; terminal until reset.
- Priority: freeze > haz > flush. A frozen cycle neither stalls nor flushes.
- stall_cycles increments on every cycle where stall_fe==1. It saturates at all-ones with no wrap.
- Reset mid-FREEZE or mid-DRAIN returns to RUN next cycle with all outputs 0.

Test Plan:
- LD r1 in EX, BEQZ r1 in decode (id_early=1) → stall_fe=1 for 2 cycles. In cycle 3, fwd_A=2'b01 while the load is in WB, then stall_fe=0 and stall_cycles=2.
- ADD r2 in MEM and ADD r2 in WB, decode reads rs=r2 → fwd_A=2'b10 (MEM priority), no stall.
- id_taken=1 with dmem_stall=1 → freeze=1, flush_ifid=0. Drop dmem_stall → flush_ifid=1 the next cycle.
- dmem_stall held for 64 cycles with MAX_FREEZE=64 → err=1 on the 64th cycle and err stays 1 after dmem_stall drops.
- HALT in decode with valid instructions in EX, MEM and WB → DRAIN for 3 cycles, then halted=1. Pulse rst=0 → halted=0 and stall_cycles=0.
